mm_mac_unit: RTL and testbench

Signed multiply-accumulate datapath directly downstream of the matrix-multiply address/control sequencer. Each cycle it takes one X operand, one A operand and the sequencer's `control` and `addr_P` for that term. It forms 6-term dot products and writes each finished sum into a 16-entry product memory P (4x4 result, row-major). P has a registered read port and a run-completion flag.

---
 rtl/mm_mac_unit_if.sv | 30 +++
 rtl/mm_mac_unit.sv | 144 ++++++++++++++
 tb/tb_mm_mac_unit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_mac_unit_if.sv
// mm_mac_unit_if: operand/control, result and read-port signals of the MAC unit.
//   master : producer side (sequencer / test driver) drives terms, Start and rd_addr
//   slave  : the MAC unit, drives results, done and rd_data
interface mm_mac_unit_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 2 * DW + 3
);
  logic             Start;
  logic             op_valid;
  logic [DW-1:0]    x_data;
  logic [DW-1:0]    a_data;
  logic             control;
  logic [3:0]       addr_P;
  logic [3:0]       rd_addr;
  logic [ACC_W-1:0] rd_data;
  logic             result_valid;
  logic [3:0]       result_addr;
  logic [ACC_W-1:0] result_data;
  logic             done;

  modport master (
    output Start, op_valid, x_data, a_data, control, addr_P, rd_addr,
    input  rd_data, result_valid, result_addr, result_data, done
  );

  modport slave (
    input  Start, op_valid, x_data, a_data, control, addr_P, rd_addr,
    output rd_data, result_valid, result_addr, result_data, done
  );
endinterface

// File: rtl/mm_mac_unit.sv
// mm_mac_unit: two-stage signed multiply-accumulate feeding a 16-entry product
// memory P (4x4 result, row-major) with a registered read port.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   bus.slave  : term inputs (op_valid, x_data, a_data, control, addr_P), Start,
//                result pulse (result_valid/addr/data), done, P read port
module mm_mac_unit #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 2 * DW + 3
) (
  input  logic          clk,
  input  logic          rst,
  mm_mac_unit_if.slave  bus
);

  localparam int unsigned PROD_W    = 2 * DW;
  localparam int unsigned EXT_W     = ACC_W - PROD_W;
  localparam int unsigned P_DEPTH   = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned N_RESULTS = 16;

  // Stage 1 registers
  logic [ACC_W-1:0] prod_q,   prod_d;
  logic             last_q,   last_d;
  logic [3:0]       p_addr_q, p_addr_d;
  logic             v1_q,     v1_d;

  // Stage 2 / accumulation state
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic             first_q,  first_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             done_q,   done_d;

  // Registered outputs
  logic             result_valid_q, result_valid_d;
  logic [3:0]       result_addr_q,  result_addr_d;
  logic [ACC_W-1:0] result_data_q,  result_data_d;
  logic [ACC_W-1:0] rd_data_q,      rd_data_d;

  // Product memory
  logic [ACC_W-1:0] mem_q [P_DEPTH];

  logic signed [PROD_W-1:0] prod_full;
  logic [ACC_W-1:0]         sum;
  logic                     wr_en;

  // Next-state logic for both pipeline stages, counters and outputs
  always_comb begin
    prod_d         = prod_q;
    last_d         = last_q;
    p_addr_d       = p_addr_q;
    v1_d           = 1'b0;
    acc_d          = acc_q;
    first_d        = first_q;
    count_d        = count_q;
    done_d         = done_q;
    result_valid_d = 1'b0;
    result_addr_d  = result_addr_q;
    result_data_d  = result_data_q;
    wr_en          = 1'b0;

    prod_full = $signed(bus.x_data) * $signed(bus.a_data);
    // Accumulator wraps modulo 2^ACC_W; first term of a dot product ignores acc.
    sum = (first_q ? '0 : acc_q) + prod_q;

    if (bus.op_valid && !bus.Start) begin
      v1_d     = 1'b1;
      prod_d   = {{EXT_W{prod_full[PROD_W-1]}}, prod_full};
      last_d   = ~bus.control;
      p_addr_d = bus.addr_P;
    end

    if (v1_q) begin
      acc_d = sum;
      if (last_q) begin
        wr_en          = 1'b1;
        result_valid_d = 1'b1;
        result_addr_d  = p_addr_q;
        result_data_d  = sum;
        first_d        = 1'b1;
        // Writes beyond the 16th in a run still land in P but are not counted.
        if (count_q < CNT_W'(N_RESULTS)) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_RESULTS - 1)) done_d = 1'b1;
        end
      end else begin
        first_d = 1'b0;
      end
    end

    // Start drops the in-flight stage-1 term; a stage-2 write above still happens.
    if (bus.Start) begin
      count_d = '0;
      done_d  = 1'b0;
      v1_d    = 1'b0;
      first_d = 1'b1;
    end

    // Read sees the pre-write contents on a same-edge collision.
    rd_data_d = mem_q[bus.rd_addr];
  end

  // Pipeline, state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q         <= '0;
      last_q         <= 1'b0;
      p_addr_q       <= '0;
      v1_q           <= 1'b0;
      acc_q          <= '0;
      first_q        <= 1'b1;
      count_q        <= '0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_addr_q  <= '0;
      result_data_q  <= '0;
      rd_data_q      <= '0;
    end else begin
      prod_q         <= prod_d;
      last_q         <= last_d;
      p_addr_q       <= p_addr_d;
      v1_q           <= v1_d;
      acc_q          <= acc_d;
      first_q        <= first_d;
      count_q        <= count_d;
      done_q         <= done_d;
      result_valid_q <= result_valid_d;
      result_addr_q  <= result_addr_d;
      result_data_q  <= result_data_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // P storage, not reset; reset suppresses the write of any in-flight result
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[p_addr_q] <= sum;
  end

  assign bus.result_valid = result_valid_q;
  assign bus.result_addr  = result_addr_q;
  assign bus.result_data  = result_data_q;
  assign bus.done         = done_q;
  assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_mm_mac_unit.sv
// tb_mm_mac_unit: randomized self-checking bench for mm_mac_unit against a
// dot-product reference model (plain integer arithmetic, truncated to ACC_W).
module tb_mm_mac_unit;

  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 2 * DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [3:0]       addr;
    logic [ACC_W-1:0] data;
    logic             done;
    int               cyc;
  } ev_t;

  ev_t              evq[$];
  logic [ACC_W-1:0] exp_full [16];

  mm_mac_unit_if #(.DW(DW), .ACC_W(ACC_W)) bus ();

  mm_mac_unit #(.DW(DW), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Collect every result pulse with the cycle it was visible in.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      ev_t e;
      e.addr = bus.result_addr;
      e.data = bus.result_data;
      e.done = bus.done;
      e.cyc  = cyc;
      evq.push_back(e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int x, input int a, input logic ctl, input logic [3:0] ad);
    bus.op_valid = 1'b1;
    bus.x_data   = DW'(x);
    bus.a_data   = DW'(a);
    bus.control  = ctl;
    bus.addr_P   = ad;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.result_valid); else n_pass++;
    n_checks++; if (bus.result_addr !== 4'd0) $display("FAIL reset_addr got %0d want 0", bus.result_addr); else n_pass++;
    n_checks++; if (bus.result_data !== '0) $display("FAIL reset_data got %0h want 0", bus.result_data); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.rd_data !== '0) $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int t;
    evq.delete();
    for (int k = 0; k < 6; k++) send(k + 1, 1, (k != 5), 4'd5);
    t = cyc;
    idle(3);
    n_checks++; if (evq.size() !== 1) $display("FAIL single_pulses got %0d want 1", evq.size()); else n_pass++;
    if (evq.size() >= 1) begin
      n_checks++; if (evq[0].addr !== 4'd5) $display("FAIL single_addr got %0d want 5", evq[0].addr); else n_pass++;
      n_checks++; if (evq[0].data !== ACC_W'(21)) $display("FAIL single_data got %0d want 21", evq[0].data); else n_pass++;
      n_checks++; if (evq[0].cyc !== t + 1) $display("FAIL single_latency got cyc %0d want %0d", evq[0].cyc, t + 1); else n_pass++;
    end
    bus.rd_addr = 4'd5;
    tick();
    n_checks++; if (bus.rd_data !== ACC_W'(21)) $display("FAIL single_readback got %0d want 21", bus.rd_data); else n_pass++;
  endtask

  task automatic test_extremes();
    logic [ACC_W-1:0] e_pos;
    logic [ACC_W-1:0] e_neg;
    e_pos = ACC_W'(98304);
    e_neg = ACC_W'(-97536);
    evq.delete();
    for (int k = 0; k < 6; k++) send(-128, -128, (k != 5), 4'd0);
    for (int k = 0; k < 6; k++) send(-128, 127, (k != 5), 4'd1);
    idle(3);
    n_checks++; if (evq.size() !== 2) $display("FAIL extremes_pulses got %0d want 2", evq.size()); else n_pass++;
    if (evq.size() >= 2) begin
      n_checks++; if (evq[0].data !== e_pos) $display("FAIL extremes_pos got %0h want %0h", evq[0].data, e_pos); else n_pass++;
      n_checks++; if (evq[1].data !== e_neg) $display("FAIL extremes_neg got %0h want %0h", evq[1].data, e_neg); else n_pass++;
    end
  endtask

  // Full 4x4 run of 6-term dot products, 96 terms with no gaps.
  task automatic test_back_to_back();
    int xm [4][6];
    int am [6][4];
    int t;
    longint s;
    for (int i = 0; i < 4; i++) for (int k = 0; k < 6; k++) xm[i][k] = rnd8();
    for (int k = 0; k < 6; k++) for (int j = 0; j < 4; j++) am[k][j] = rnd8();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 6; k++) s += longint'(xm[i][k] * am[k][j]);
        exp_full[i * 4 + j] = ACC_W'(s);
      end
    pulse_start();
    n_checks++; if (bus.done !== 1'b0) $display("FAIL full_done_cleared got %b want 0", bus.done); else n_pass++;
    evq.delete();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 6; k++) send(xm[i][k], am[k][j], (k != 5), 4'(i * 4 + j));
    t = cyc;
    idle(3);
    n_checks++; if (evq.size() !== 16) $display("FAIL full_pulses got %0d want 16", evq.size()); else n_pass++;
    if (evq.size() == 16) begin
      for (int p = 0; p < 16; p++) begin
        n_checks++; if (evq[p].addr !== 4'(p)) $display("FAIL full_addr[%0d] got %0d want %0d", p, evq[p].addr, p); else n_pass++;
        n_checks++; if (evq[p].data !== exp_full[p]) $display("FAIL full_data[%0d] got %0h want %0h", p, evq[p].data, exp_full[p]); else n_pass++;
        n_checks++; if (evq[p].done !== (p == 15)) $display("FAIL full_done_at[%0d] got %b want %b", p, evq[p].done, (p == 15)); else n_pass++;
      end
      n_checks++; if (evq[15].cyc !== t + 1) $display("FAIL full_last_latency got cyc %0d want %0d", evq[15].cyc, t + 1); else n_pass++;
    end
    n_checks++; if (bus.done !== 1'b1) $display("FAIL full_done_hold got %b want 1", bus.done); else n_pass++;
    for (int p = 0; p < 16; p++) begin
      bus.rd_addr = 4'(p);
      tick();
      n_checks++; if (bus.rd_data !== exp_full[p]) $display("FAIL full_readback[%0d] got %0h want %0h", p, bus.rd_data, exp_full[p]); else n_pass++;
    end
  endtask

  task automatic test_bubbles();
    int xv [6];
    int av [6];
    int nb;
    int t0;
    longint s;
    logic [3:0] ad;
    for (int rep = 0; rep < 3; rep++) begin
      s = 0;
      for (int k = 0; k < 6; k++) begin
        xv[k] = rnd8();
        av[k] = rnd8();
        s += longint'(xv[k] * av[k]);
      end
      nb = int'($urandom_range(1, 3));
      ad = 4'($urandom_range(0, 15));
      evq.delete();
      for (int k = 0; k < 6; k++) begin
        send(xv[k], av[k], (k != 5), ad);
        if (k == 0) t0 = cyc;
        if (k == 2) idle(nb);
      end
      idle(3);
      n_checks++; if (evq.size() !== 1) $display("FAIL bubble_pulses got %0d want 1", evq.size()); else n_pass++;
      if (evq.size() >= 1) begin
        n_checks++; if (evq[0].data !== ACC_W'(s)) $display("FAIL bubble_data got %0h want %0h", evq[0].data, ACC_W'(s)); else n_pass++;
        n_checks++; if (evq[0].addr !== ad) $display("FAIL bubble_addr got %0d want %0d", evq[0].addr, ad); else n_pass++;
        n_checks++; if (evq[0].cyc !== t0 + 6 + nb) $display("FAIL bubble_latency got cyc %0d want %0d", evq[0].cyc, t0 + 6 + nb); else n_pass++;
      end
    end
  endtask

  task automatic test_start_abort();
    evq.delete();
    for (int k = 0; k < 3; k++) send(rnd8(), rnd8(), 1'b1, 4'd3);
    // Term offered together with Start is a would-be last term; it must vanish.
    bus.op_valid = 1'b1;
    bus.x_data   = DW'(rnd8());
    bus.a_data   = DW'(rnd8());
    bus.control  = 1'b0;
    bus.addr_P   = 4'd3;
    pulse_start();
    bus.op_valid = 1'b0;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL abort_done got %b want 0", bus.done); else n_pass++;
    for (int k = 0; k < 6; k++) send(2, 2, (k != 5), 4'd9);
    idle(3);
    n_checks++; if (evq.size() !== 1) $display("FAIL abort_pulses got %0d want 1", evq.size()); else n_pass++;
    if (evq.size() >= 1) begin
      n_checks++; if (evq[0].addr !== 4'd9) $display("FAIL abort_addr got %0d want 9", evq[0].addr); else n_pass++;
      n_checks++; if (evq[0].data !== ACC_W'(24)) $display("FAIL abort_data got %0d want 24", evq[0].data); else n_pass++;
    end
    bus.rd_addr = 4'd3;
    tick();
    n_checks++; if (bus.rd_data !== exp_full[3]) $display("FAIL abort_p3_untouched got %0h want %0h", bus.rd_data, exp_full[3]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    bus.rd_addr = 4'd0;
    for (int k = 0; k < 20; k++) send(rnd8(), rnd8(), ((k % 6) != 5), 4'(k / 6));
    // Reset with a valid last term on the inputs and another term in stage 2.
    bus.op_valid = 1'b1;
    bus.x_data   = DW'(7);
    bus.a_data   = DW'(9);
    bus.control  = 1'b0;
    bus.addr_P   = 4'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.op_valid = 1'b0;
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus.result_valid); else n_pass++;
    n_checks++; if (bus.result_addr !== 4'd0) $display("FAIL rstmid_addr got %0d want 0", bus.result_addr); else n_pass++;
    n_checks++; if (bus.result_data !== '0) $display("FAIL rstmid_data got %0h want 0", bus.result_data); else n_pass++;
    n_checks++; if (bus.rd_data !== '0) $display("FAIL rstmid_rd_data got %0h want 0", bus.rd_data); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done got %b want 0", bus.done); else n_pass++;
    evq.delete();
    idle(4);
    n_checks++; if (evq.size() !== 0) $display("FAIL rstmid_no_write got %0d pulses want 0", evq.size()); else n_pass++;
    test_back_to_back();
  endtask

  initial begin
    bus.Start    = 1'b0;
    bus.op_valid = 1'b0;
    bus.x_data   = '0;
    bus.a_data   = '0;
    bus.control  = 1'b0;
    bus.addr_P   = '0;
    bus.rd_addr  = '0;
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_bubbles();
    test_start_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
